// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 16;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_MULS = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  // state | meaning
  // IDLE  | waiting for start
  // PREP  | magnitudes and result signs
  // RUN   | one shift-add / restoring-subtract step per cycle
  // FIX   | sign correction, special cases, register hi/lo
  // DONE  | one-cycle result-valid
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply or
// restoring divide, selected by i_div.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             i_div,
  input  logic [WIDTH:0]   i_acc,
  input  logic [WIDTH-1:0] i_sh,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_acc,
  output logic [WIDTH-1:0] o_sh
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_shl;
  logic [WIDTH:0] w_trial;
  logic [WIDTH:0] w_add;

  assign w_sum   = i_acc + {1'b0, i_m};
  assign w_shl   = {i_acc[WIDTH-1:0], i_sh[WIDTH-1]};
  assign w_trial = w_shl - {1'b0, i_m};

  // Multiply shifts the accumulator/multiplier pair right; divide shifts the
  // remainder/dividend pair left and keeps the trial difference when non-negative.
  always_comb begin
    w_add = '0;
    o_acc = '0;
    o_sh  = '0;
    if (!i_div) begin
      w_add = i_sh[0] ? w_sum : i_acc;
      o_acc = {1'b0, w_add[WIDTH:1]};
      o_sh  = {w_add[0], i_sh[WIDTH-1:1]};
    end else if (!w_trial[WIDTH]) begin
      o_acc = w_trial;
      o_sh  = {i_sh[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = w_shl;
      o_sh  = {i_sh[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit. Stalls the front of the pipeline
// while an op runs and presents a registered result with its destination id.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int REG_W = 4,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [REG_W-1:0] dstIn,
  input  logic             wbIn,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [REG_W-1:0] dstOut,
  output logic             wbOut,
  output logic             divZero
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             r_state, w_next;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [REG_W-1:0]   r_dst;
  logic               r_wb;
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_sh, r_m;
  logic               r_sgn_q, r_sgn_r;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_divz;

  logic               w_is_div, w_signed, w_last;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_acc_nxt;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;
  logic               w_fix_dz;

  assign w_is_div = r_op[0];
  assign w_signed = r_op[1];
  assign w_last   = (r_cnt == CNT_W'(ITER - 1));
  assign w_mag_a  = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
  assign w_mag_b  = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_is_div),
    .i_acc (r_acc),
    .i_sh  (r_sh),
    .i_m   (r_m),
    .o_acc (w_acc_nxt),
    .o_sh  (w_sh_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic; flush aborts everything past IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = PREP;
      PREP:    w_next = flush ? IDLE : RUN;
      RUN:     w_next = flush ? IDLE : (w_last ? FIX : RUN);
      FIX:     w_next = flush ? IDLE : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs; stall drops in DONE so the pipeline advances with the result.
  always_comb begin
    busy  = (r_state != IDLE);
    done  = (r_state == DONE);
    stall = (start && (r_state == IDLE)) || (r_state == PREP) ||
            (r_state == RUN) || (r_state == FIX);
  end

  // Final result: sign fix-up plus divide-by-zero and signed-overflow cases.
  always_comb begin
    w_prod   = {r_acc[WIDTH-1:0], r_sh};
    w_prod_s = r_sgn_q ? -w_prod : w_prod;
    w_fix_dz = 1'b0;
    if (!w_is_div) begin
      w_fix_hi = w_prod_s[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod_s[WIDTH-1:0];
    end else if (r_b == '0) begin
      w_fix_hi = r_a;
      w_fix_lo = '1;
      w_fix_dz = 1'b1;
    end else if (w_signed && (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1)) begin
      w_fix_hi = '0;
      w_fix_lo = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      w_fix_hi = r_sgn_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      w_fix_lo = r_sgn_q ? -r_sh : r_sh;
    end
  end

  // Operand latch, iteration datapath, counter and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_dst   <= '0;
      r_wb    <= 1'b0;
      r_acc   <= '0;
      r_sh    <= '0;
      r_m     <= '0;
      r_sgn_q <= 1'b0;
      r_sgn_r <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_divz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_op  <= op;
          r_a   <= opA;
          r_b   <= opB;
          r_dst <= dstIn;
          r_wb  <= wbIn;
        end
        PREP: begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_sh    <= w_is_div ? w_mag_a : w_mag_b;
          r_m     <= w_is_div ? w_mag_b : w_mag_a;
          r_sgn_q <= w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_sgn_r <= w_signed && r_a[WIDTH-1];
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: if (!flush) begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_divz <= w_fix_dz;
        end
        default: ;
      endcase
    end
  end

  assign hi      = r_hi;
  assign lo      = r_lo;
  assign dstOut  = r_dst;
  assign wbOut   = r_wb;
  assign divZero = r_divz && done;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] opA = '0, opB = '0;
  logic [3:0]  dstIn = '0;
  logic        wbIn = 1'b0;
  logic        flush = 1'b0;
  logic        stall, busy, done, wbOut, divZero;
  logic [15:0] hi, lo;
  logic [3:0]  dstOut;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .dstIn(dstIn), .wbIn(wbIn), .flush(flush), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .dstOut(dstOut), .wbOut(wbOut),
    .divZero(divZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  dst;
    logic        wb;
    logic        dz;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, want);
    end
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest pending op.
  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got=done want=no_done");
      end else begin
        e = q.pop_front();
        chk("hi", {16'h0, hi}, {16'h0, e.hi});
        chk("lo", {16'h0, lo}, {16'h0, e.lo});
        chk("dstOut", {28'h0, dstOut}, {28'h0, e.dst});
        chk("wbOut", {31'h0, wbOut}, {31'h0, e.wb});
        chk("divZero", {31'h0, divZero}, {31'h0, e.dz});
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d, input logic w, input logic [15:0] ehi,
                       input logic [15:0] elo, input logic edz, input bit push);
    exp_t x;
    @(negedge clk);
    start = 1'b1; op = o; opA = a; opB = b; dstIn = d; wbIn = w;
    #1 chk("stall_on_start", {31'h0, stall}, 32'h1);
    @(posedge clk);
    #1 start = 1'b0;
    if (push) begin
      x.hi = ehi; x.lo = elo; x.dst = d; x.wb = w; x.dz = edz;
      q.push_back(x);
    end
  endtask

  // Waits for done after the start edge; inj>=0 re-asserts start with other
  // operands for one cycle at that many cycles in.
  task automatic wait_done(input int inj);
    int cycles;
    int stall_err;
    stall_err = 0;
    for (cycles = 0; cycles < 40; cycles++) begin
      @(negedge clk);
      if (cycles == inj) begin
        start = 1'b1; op = OP_MULU; opA = 16'h0005; opB = 16'h0003;
        dstIn = 4'h3; wbIn = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!stall || !busy) stall_err++;
    end
    start = 1'b0;
    chk("latency", cycles, 18);
    chk("stall_busy_during_op", stall_err, 0);
    chk("stall_in_done", {31'h0, stall}, 32'h0);
    chk("busy_in_done", {31'h0, busy}, 32'h1);
    @(posedge clk);
    #1 chk("busy_after_done", {30'h0, busy, done}, 32'h0);
  endtask

  initial begin
    #12;
    chk("rst_outputs", {hi, lo}, 32'h0);
    chk("rst_ctrl", {26'h0, dstOut, wbOut, done, busy, divZero}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    issue(OP_MULU, 16'hFFFF, 16'hFFFF, 4'h1, 1'b1, 16'hFFFE, 16'h0001, 1'b0, 1'b1);
    wait_done(-1);
    issue(OP_MULS, 16'hFFFD, 16'h0007, 4'h2, 1'b0, 16'hFFFF, 16'hFFEB, 1'b0, 1'b1);
    wait_done(-1);
    issue(OP_DIVS, 16'hFFF9, 16'h0002, 4'h3, 1'b1, 16'hFFFF, 16'hFFFD, 1'b0, 1'b1);
    wait_done(-1);
    issue(OP_DIVU, 16'h1234, 16'h0000, 4'h4, 1'b1, 16'h1234, 16'hFFFF, 1'b1, 1'b1);
    wait_done(-1);
    issue(OP_DIVS, 16'h8000, 16'hFFFF, 4'h5, 1'b1, 16'h0000, 16'h8000, 1'b0, 1'b1);
    wait_done(-1);
    issue(OP_MULS, 16'h8000, 16'h8000, 4'h6, 1'b1, 16'h4000, 16'h0000, 1'b0, 1'b1);
    wait_done(-1);

    issue(OP_DIVU, 16'd100, 16'd7, 4'hA, 1'b1, 16'd2, 16'd14, 1'b0, 1'b1);
    wait_done(6);
    repeat (25) @(posedge clk);

    issue(OP_DIVU, 16'h0050, 16'h0003, 4'h7, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_idle", {30'h0, busy, done}, 32'h0);
    chk("flush_keep_hilo", {hi, lo}, {16'd2, 16'd14});
    issue(OP_MULU, 16'd6, 16'd7, 4'h8, 1'b1, 16'h0, 16'd42, 1'b0, 1'b1);
    wait_done(-1);

    issue(OP_MULU, 16'd9, 16'd9, 4'h9, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_hilo", {hi, lo}, 32'h0);
    chk("arst_ctrl", {26'h0, dstOut, wbOut, done, busy, divZero}, 32'h0);
    chk("arst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    issue(OP_MULU, 16'd3, 16'd5, 4'hB, 1'b1, 16'h0, 16'd15, 1'b0, 1'b1);
    wait_done(-1);

    repeat (25) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
